// File: rtl/ysyx_24070017_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states and master IDs.
package ysyx_24070017_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24070017_mux_key.sv
// Keyed selector: out takes the data of the lut entry whose key matches, else default_out.
// Purely combinational; lut is packed as {key, data} pairs, entry 0 in the low bits.
module ysyx_24070017_mux_key #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   output logic [DATA_LEN-1:0]                  out,
   input  logic [KEY_LEN-1:0]                   key,
   input  logic [DATA_LEN-1:0]                  default_out,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

   always_comb begin
      out = default_out;
      for (int i = 0; i < NR_KEY; i++) begin
         if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
            out = lut[i*PAIR_LEN +: DATA_LEN];
         end
      end
   end

endmodule

// File: rtl/ysyx_24070017_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, on contention the one not granted last wins.
// Combinational, no state; the caller owns last_grant.
module ysyx_24070017_rr_pick
   import ysyx_24070017_bus_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_valid
);

   always_comb begin
      any_valid = |valid;
      grant     = MST_IFU;
      if (valid[MST_LSU] && (!valid[MST_IFU] || last_grant == MST_IFU)) begin
         grant = MST_LSU;
      end
   end

endmodule

// File: rtl/ysyx_24070017_bus_arbiter.sv
// Arbitrates IFU/LSU onto one memory slave, one transaction outstanding; grant-to-slave 1 cycle,
// min 3 cycles per transaction. Ready/valid pass straight through to the granted master only.
module ysyx_24070017_bus_arbiter
   import ysyx_24070017_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic                m0_wen,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wmask,
   output logic                m0_resp_valid,
   input  logic                m0_resp_ready,
   output logic [DATA_W-1:0]   m0_rdata,

   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic                m1_wen,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wmask,
   output logic                m1_resp_valid,
   input  logic                m1_resp_ready,
   output logic [DATA_W-1:0]   m1_rdata,

   output logic                s_req_valid,
   input  logic                s_req_ready,
   output logic [ADDR_W-1:0]   s_addr,
   output logic                s_wen,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wmask,
   input  logic                s_resp_valid,
   output logic                s_resp_ready,
   input  logic [DATA_W-1:0]   s_rdata
);

   localparam int MASK_W = DATA_W / 8;
   localparam int PAY_W  = ADDR_W + 1 + DATA_W + MASK_W;

   arb_state_t       state, state_nxt;
   logic             g, g_nxt;
   logic             last_grant, last_grant_nxt;
   logic             pick_grant, pick_any;
   logic             mg_resp_ready;
   logic [1:0]       req_key, resp_key;
   logic [PAY_W-1:0] m0_pay, m1_pay, s_pay;

   ysyx_24070017_rr_pick u_pick (
      .valid      ({m1_req_valid, m0_req_valid}),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .any_valid  (pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         g          <= MST_IFU;
         last_grant <= MST_LSU;
      end else begin
         state      <= state_nxt;
         g          <= g_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Keys carry the phase bit so every steered output falls to zero outside its phase.
   assign req_key  = {state == REQ,  g};
   assign resp_key = {state == RESP, g};
   assign m0_pay   = {m0_addr, m0_wen, m0_wdata, m0_wmask};
   assign m1_pay   = {m1_addr, m1_wen, m1_wdata, m1_wmask};
   assign {s_addr, s_wen, s_wdata, s_wmask} = s_pay;

   ysyx_24070017_mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(PAY_W)) u_req_mux (
      .out         (s_pay),
      .key         (req_key),
      .default_out ({PAY_W{1'b0}}),
      .lut         ({2'b11, m1_pay, 2'b10, m0_pay})
   );

   ysyx_24070017_mux_key #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(DATA_W)) u_m0_rdata_mux (
      .out         (m0_rdata),
      .key         (resp_key),
      .default_out ({DATA_W{1'b0}}),
      .lut         ({2'b10, s_rdata})
   );

   ysyx_24070017_mux_key #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(DATA_W)) u_m1_rdata_mux (
      .out         (m1_rdata),
      .key         (resp_key),
      .default_out ({DATA_W{1'b0}}),
      .lut         ({2'b11, s_rdata})
   );

   ysyx_24070017_mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(1)) u_rready_mux (
      .out         (mg_resp_ready),
      .key         (g),
      .default_out (1'b0),
      .lut         ({MST_LSU, m1_resp_ready, MST_IFU, m0_resp_ready})
   );

   always_comb begin
      state_nxt      = state;
      g_nxt          = g;
      last_grant_nxt = last_grant;
      s_req_valid    = 1'b0;
      s_resp_ready   = 1'b0;
      m0_req_ready   = 1'b0;
      m1_req_ready   = 1'b0;
      m0_resp_valid  = 1'b0;
      m1_resp_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               g_nxt     = pick_grant;
               state_nxt = REQ;
            end
         end
         REQ: begin
            s_req_valid  = 1'b1;
            m0_req_ready = (g == MST_IFU) && s_req_ready;
            m1_req_ready = (g == MST_LSU) && s_req_ready;
            if (s_req_ready) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            s_resp_ready  = mg_resp_ready;
            m0_resp_valid = (g == MST_IFU) && s_resp_valid;
            m1_resp_valid = (g == MST_LSU) && s_resp_valid;
            if (s_resp_valid && mg_resp_ready) begin
               last_grant_nxt = g;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_24070017_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level arbiter model.
module tb_ysyx_24070017_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wmask;
   logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wmask;
   logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wmask;

   logic        mv [2];
   logic [31:0] ma [2];
   logic        mw [2];
   logic [31:0] md [2];
   logic [3:0]  mk [2];
   logic        mr [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_24070017_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
      .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_resp_valid(m0_resp_valid),
      .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
      .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_resp_valid(m1_resp_valid),
      .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr), .s_wen(s_wen),
      .s_wdata(s_wdata), .s_wmask(s_wmask), .s_resp_valid(s_resp_valid),
      .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
   );

   task automatic drive_masters();
      m0_req_valid = mv[0]; m0_addr = ma[0]; m0_wen = mw[0]; m0_wdata = md[0];
      m0_wmask = mk[0]; m0_resp_ready = mr[0];
      m1_req_valid = mv[1]; m1_addr = ma[1]; m1_wen = mw[1]; m1_wdata = md[1];
      m1_wmask = mk[1]; m1_resp_ready = mr[1];
   endtask

   task automatic clear_inputs();
      for (int m = 0; m < 2; m++) begin
         mv[m] = 1'b0; ma[m] = '0; mw[m] = 1'b0; md[m] = '0; mk[m] = '0; mr[m] = 1'b0;
      end
      s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
      drive_masters();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after a rising edge with the DUT in IDLE.
   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_txn(input int m);
      mv[m] = 1'b1; ma[m] = $urandom; drive_masters();
      s_req_ready = 1'b1;
      step();
      step();
      mv[m] = 1'b0; mr[m] = 1'b1; s_resp_valid = 1'b1; drive_masters();
      step();
      mr[m] = 1'b0; s_resp_valid = 1'b0; drive_masters();
   endtask

   task automatic test_reset();
      logic [68:0] sp;
      clear_inputs();
      rst_n = 1'b0;
      mv[0] = 1'b1; mv[1] = 1'b1; mr[0] = 1'b1; mr[1] = 1'b1;
      ma[0] = $urandom; ma[1] = $urandom; drive_masters();
      s_req_ready = 1'b1; s_resp_valid = 1'b1; s_rdata = $urandom;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_handshakes: got %b required 000000",
                  {s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid});
      end
      sp = {s_addr, s_wen, s_wdata, s_wmask};
      checks++;
      if (sp !== '0) begin
         errors++;
         $display("FAIL reset_payload: got %h required 0", sp);
      end
   endtask

   task automatic test_single_read();
      apply_reset();
      mv[0] = 1'b1; ma[0] = 32'h8000_0000; mr[0] = 1'b1; drive_masters();
      s_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_req_valid !== 1'b0) begin
         errors++; $display("FAIL read_cycle0_sreq: got %b required 0", s_req_valid);
      end
      step();
      @(negedge clk);
      checks++;
      if ({s_req_valid, m0_req_ready, s_wen, s_addr} !== {3'b110, 32'h8000_0000}) begin
         errors++;
         $display("FAIL read_cycle1_req: got v=%b rdy=%b wen=%b addr=%h required 1 1 0 80000000",
                  s_req_valid, m0_req_ready, s_wen, s_addr);
      end
      step();
      mv[0] = 1'b0; drive_masters();
      s_resp_valid = 1'b1; s_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if ({m0_resp_valid, s_resp_ready, m0_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL read_cycle2_resp: got v=%b srdy=%b rdata=%h required 1 1 deadbeef",
                  m0_resp_valid, s_resp_ready, m0_rdata);
      end
      checks++;
      if ({m1_req_ready, m1_resp_valid, m1_rdata} !== 34'h0) begin
         errors++;
         $display("FAIL read_m1_quiet: got rdy=%b v=%b rdata=%h required 0 0 0",
                  m1_req_ready, m1_resp_valid, m1_rdata);
      end
      step();
      s_resp_valid = 1'b0;
   endtask

   task automatic test_alternate();
      int e;
      logic [31:0] rd;
      apply_reset();
      for (int m = 0; m < 2; m++) begin
         mv[m] = 1'b1; ma[m] = $urandom; md[m] = $urandom; mr[m] = 1'b1;
      end
      drive_masters();
      s_req_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         e = t % 2;
         step();
         @(negedge clk);
         checks++;
         if ({m1_req_ready, m0_req_ready} !== ((e == 1) ? 2'b10 : 2'b01) ||
             s_addr !== ma[e] || s_wdata !== md[e]) begin
            errors++;
            $display("FAIL alt_grant_%0d: got rdy=%b%b addr=%h wdata=%h required master %0d addr=%h wdata=%h",
                     t, m1_req_ready, m0_req_ready, s_addr, s_wdata, e, ma[e], md[e]);
         end
         step();
         ma[e] = $urandom; md[e] = $urandom; drive_masters();
         rd = $urandom; s_resp_valid = 1'b1; s_rdata = rd;
         @(negedge clk);
         checks++;
         if ({m1_resp_valid, m0_resp_valid} !== ((e == 1) ? 2'b10 : 2'b01) ||
             ((e == 1) ? m1_rdata : m0_rdata) !== rd) begin
            errors++;
            $display("FAIL alt_resp_%0d: got v=%b%b rdata0=%h rdata1=%h required master %0d rdata=%h",
                     t, m1_resp_valid, m0_resp_valid, m0_rdata, m1_rdata, e, rd);
         end
         step();
         s_resp_valid = 1'b0;
      end
   endtask

   task automatic test_write_stall();
      apply_reset();
      mv[1] = 1'b1; ma[1] = 32'h8000_1000; mw[1] = 1'b1; md[1] = 32'h1234_5678; mk[1] = 4'hF;
      drive_masters();
      step();
      for (int c = 0; c < 5; c++) begin
         s_req_ready = (c == 4);
         @(negedge clk);
         checks++;
         if ({s_req_valid, s_addr, s_wen, s_wdata, s_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF}) begin
            errors++;
            $display("FAIL stall_payload_%0d: got v=%b addr=%h wen=%b wdata=%h mask=%h required 1 80001000 1 12345678 f",
                     c, s_req_valid, s_addr, s_wen, s_wdata, s_wmask);
         end
         checks++;
         if ({m1_req_ready, m0_req_ready} !== {(c == 4), 1'b0}) begin
            errors++;
            $display("FAIL stall_ready_%0d: got %b%b required %b0", c, m1_req_ready, m0_req_ready, (c == 4));
         end
         step();
      end
      mv[1] = 1'b0; mr[1] = 1'b1; drive_masters();
      s_req_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({m1_resp_valid, s_resp_ready, m1_rdata} !== {2'b11, s_rdata}) begin
         errors++;
         $display("FAIL stall_resp: got v=%b srdy=%b rdata=%h required 1 1 %h",
                  m1_resp_valid, s_resp_ready, m1_rdata, s_rdata);
      end
      step();
      s_resp_valid = 1'b0;
   endtask

   task automatic test_resp_backpressure();
      apply_reset();
      mv[0] = 1'b1; ma[0] = $urandom; drive_masters();
      s_req_ready = 1'b1;
      step();
      step();
      mv[0] = 1'b0; mr[0] = 1'b0; drive_masters();
      s_resp_valid = 1'b1; s_rdata = $urandom;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({s_resp_ready, m0_resp_valid} !== 2'b01) begin
            errors++;
            $display("FAIL bp_hold_%0d: got srdy=%b v=%b required 0 1", c, s_resp_ready, m0_resp_valid);
         end
         step();
      end
      mr[0] = 1'b1; drive_masters();
      @(negedge clk);
      checks++;
      if ({s_resp_ready, m0_resp_valid, m0_rdata} !== {2'b11, s_rdata}) begin
         errors++;
         $display("FAIL bp_complete: got srdy=%b v=%b rdata=%h required 1 1 %h",
                  s_resp_ready, m0_resp_valid, m0_rdata, s_rdata);
      end
      step();
      @(negedge clk);
      checks++;
      if ({s_resp_ready, m0_resp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL bp_left_resp: got srdy=%b v=%b required 0 0", s_resp_ready, m0_resp_valid);
      end
      step();
      s_resp_valid = 1'b0;
   endtask

   task automatic test_reset_in_resp();
      apply_reset();
      do_txn(0);
      mv[0] = 1'b1; ma[0] = $urandom; drive_masters();
      s_req_ready = 1'b1;
      step();
      step();
      mv[0] = 1'b0; mr[0] = 1'b0; drive_masters();
      s_resp_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (m0_resp_valid !== 1'b1) begin
         errors++; $display("FAIL rr_in_resp: got v=%b required 1", m0_resp_valid);
      end
      mr[0] = 1'b1; drive_masters();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL rr_async_clear: got %b required 000000",
                  {s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      s_resp_valid = 1'b0; mr[0] = 1'b0; drive_masters();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({s_req_valid, m0_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rr_no_replay_%0d: got sreq=%b v=%b required 0 0", c, s_req_valid, m0_resp_valid);
         end
         step();
      end
      mv[0] = 1'b1; mv[1] = 1'b1; ma[0] = $urandom; ma[1] = $urandom; drive_masters();
      step();
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b01 || s_addr !== ma[0]) begin
         errors++;
         $display("FAIL rr_first_contention: got rdy=%b%b addr=%h required 01 addr=%h",
                  m1_req_ready, m0_req_ready, s_addr, ma[0]);
      end
   endtask

   task automatic test_spurious_resp();
      apply_reset();
      mr[0] = 1'b1; mr[1] = 1'b1; drive_masters();
      s_resp_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         s_rdata = $urandom;
         @(negedge clk);
         checks++;
         if ({s_resp_ready, m1_resp_valid, m0_resp_valid, s_req_valid} !== 4'b0) begin
            errors++;
            $display("FAIL spurious_%0d: got srdy=%b v1=%b v0=%b sreq=%b required 0 0 0 0",
                     c, s_resp_ready, m1_resp_valid, m0_resp_valid, s_req_valid);
         end
         step();
      end
      s_resp_valid = 1'b0;
   endtask

   // Model: phase 0 = free, 1 = request offered to slave, 2 = awaiting response.
   task automatic test_random();
      int          phase, owner, lg;
      logic        sl_hold;
      logic [68:0] exp_pay, got_pay;
      logic [1:0]  exp_vec;
      apply_reset();
      phase = 0; owner = 0; lg = 1; sl_hold = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (!mv[m] && ($urandom % 3 == 0)) begin
               mv[m] = 1'b1; ma[m] = $urandom; mw[m] = $urandom; md[m] = $urandom; mk[m] = $urandom;
            end
            mr[m] = $urandom;
         end
         drive_masters();
         s_req_ready = $urandom;
         if (!sl_hold) begin
            s_resp_valid = ($urandom % 3 == 0);
            s_rdata = $urandom;
            if (phase == 2 && s_resp_valid) sl_hold = 1'b1;
         end
         @(negedge clk);
         checks++;
         if (s_req_valid !== (phase == 1)) begin
            errors++; $display("FAIL rnd_sreq_valid cyc %0d: got %b required %b", cyc, s_req_valid, phase == 1);
         end
         exp_vec = (phase == 1 && s_req_ready) ? 2'(1 << owner) : 2'b00;
         checks++;
         if ({m1_req_ready, m0_req_ready} !== exp_vec) begin
            errors++; $display("FAIL rnd_req_ready cyc %0d: got %b%b required %b", cyc, m1_req_ready, m0_req_ready, exp_vec);
         end
         exp_pay = (phase == 1) ? {ma[owner], mw[owner], md[owner], mk[owner]} : '0;
         got_pay = {s_addr, s_wen, s_wdata, s_wmask};
         checks++;
         if (got_pay !== exp_pay) begin
            errors++; $display("FAIL rnd_payload cyc %0d: got %h required %h", cyc, got_pay, exp_pay);
         end
         checks++;
         if (s_resp_ready !== ((phase == 2) ? mr[owner] : 1'b0)) begin
            errors++; $display("FAIL rnd_sresp_ready cyc %0d: got %b required %b", cyc, s_resp_ready,
                               (phase == 2) ? mr[owner] : 1'b0);
         end
         exp_vec = (phase == 2 && s_resp_valid) ? 2'(1 << owner) : 2'b00;
         checks++;
         if ({m1_resp_valid, m0_resp_valid} !== exp_vec) begin
            errors++; $display("FAIL rnd_resp_valid cyc %0d: got %b%b required %b", cyc, m1_resp_valid, m0_resp_valid, exp_vec);
         end
         if (phase == 2 && s_resp_valid) begin
            checks++;
            if (((owner == 1) ? m1_rdata : m0_rdata) !== s_rdata) begin
               errors++; $display("FAIL rnd_rdata cyc %0d: got %h required %h", cyc,
                                  (owner == 1) ? m1_rdata : m0_rdata, s_rdata);
            end
         end
         if (phase == 0) begin
            if (mv[0] || mv[1]) begin
               owner = (mv[0] && mv[1]) ? 1 - lg : (mv[1] ? 1 : 0);
               phase = 1;
            end
         end else if (phase == 1) begin
            if (s_req_ready) begin
               mv[owner] = 1'b0;
               phase = 2;
            end
         end else if (s_resp_valid && mr[owner]) begin
            lg = owner;
            phase = 0;
            sl_hold = 1'b0;
         end
         step();
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_read();
      test_alternate();
      test_write_stall();
      test_resp_backpressure();
      test_reset_in_resp();
      test_spurious_resp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_24070017_bus_arbiter.md
YSYX_24070017_BUS_ARBITER -- requirements
Module: ysyx_24070017_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the request address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the write and read data width; the write mask is DATA_W/8 bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 mI_req_valid / mI_req_ready  in/out  1  SHALL carry the request handshake for master I (I=0 IFU, I=1 LSU).
REQ-006 mI_addr, mI_wen, mI_wdata, mI_wmask  input  ADDR_W/1/DATA_W/DATA_W/8  SHALL carry the master I request payload.
REQ-007 mI_resp_valid / mI_resp_ready  out/in  1  SHALL carry the response handshake for master I.
REQ-008 mI_rdata  output  DATA_W  SHALL carry response data to master I.
REQ-009 s_req_valid / s_req_ready  out/in  1  SHALL carry the request handshake to the shared memory slave.
REQ-010 s_addr, s_wen, s_wdata, s_wmask  output  same widths  SHALL carry the forwarded request payload.
REQ-011 s_resp_valid / s_resp_ready  in/out  1, s_rdata  input  DATA_W  SHALL carry the slave response.

Function
REQ-012 Handshake rule on every channel: a transfer occurs in a cycle where valid and ready are both 1; the source holds valid and payload stable until the transfer.
REQ-013 The FSM SHALL have three states: IDLE, REQ, RESP.
REQ-014 IDLE: if any mI_req_valid=1, latch grant g and go to REQ next cycle; otherwise stay. No master sees ready in IDLE.
REQ-015 Arbitration: one valid request wins alone. When both are valid, the master other than last_grant wins (round-robin).
REQ-016 REQ: s_req_valid=1; s_addr/s_wen/s_wdata/s_wmask come from master g. mg_req_ready SHALL equal s_req_ready combinationally. On the s_req transfer, go to RESP.
REQ-017 RESP: mg_resp_valid SHALL equal s_resp_valid, mg_rdata SHALL equal s_rdata, and s_resp_ready SHALL equal mg_resp_ready. On the s_resp transfer, set last_grant=g and return to IDLE.
REQ-018 The non-granted master SHALL see req_ready=0 and resp_valid=0 at all times. Its request stays pending without loss.
REQ-019 s_req_valid SHALL be 0 outside REQ; s_resp_ready SHALL be 0 outside RESP. The slave payload outputs are 0 outside REQ.
REQ-020 Latency: a request seen in IDLE in cycle N is presented to the slave in cycle N+1. The minimum turnaround per transaction is 3 cycles (IDLE, REQ, RESP).
REQ-021 Only one transaction SHALL be outstanding. A new grant is made only in IDLE, after the response completes.
REQ-022 Slave responses arriving in any state other than RESP SHALL be ignored (s_resp_ready=0).
REQ-023 A change in the other master's request during REQ or RESP SHALL NOT alter g.

Reset
REQ-024 Asserting rst_n=0 in any state SHALL immediately force: state=IDLE, g=0, last_grant=1 (so master 0 wins the first contention), and every ready/valid output 0.
REQ-025 An in-flight transaction aborted by reset SHALL NOT be replayed after reset is released.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE/REQ/RESP) and the master ID constants (MST_IFU=0, MST_LSU=1).
REQ-027 Round-robin selection SHALL be a sub-module, ysyx_24070017_rr_pick (inputs: 2 valid bits and last_grant; outputs: grant index and any_valid).
REQ-028 All payload steering SHALL be built from the team's MuxKey selector templates keyed on g.

Verification
REQ-029 Bench: m0 only reads addr 0x80000000, slave ready immediately, rdata 0xDEADBEEF -> s_req_valid high in cycle 1, m0_resp_valid with 0xDEADBEEF in cycle 2, m1 outputs stay 0.
REQ-030 Bench: m0 and m1 both valid from reset -> grants m0, m1, m0, m1 alternate; each master's address and data route only to that master.
REQ-031 Bench: m1 write addr 0x80001000, wdata 0x12345678, wmask 0xF, slave holds s_req_ready=0 for 4 cycles -> payload stable at s_* for all 5 cycles, m1_req_ready pulses only in the transfer cycle.
REQ-032 Bench: s_resp_valid=1 with m0_resp_ready=0 for 3 cycles -> s_resp_ready=0, FSM stays in RESP, completes on the first cycle m0_resp_ready=1.
REQ-033 Bench: rst_n dropped while in RESP -> all outputs 0 in the same cycle; after release, FSM is IDLE and master 0 wins the next contention.
REQ-034 Bench: spurious s_resp_valid=1 while in IDLE -> s_resp_ready=0, both mI_resp_valid stay 0.
